// File: rtl/stm_pkg.sv
// +-----------------------------------------------------------------------------+
// | stm_pkg : shared definitions for the 3-state sequence generator / checker   |
// | Rev 1.0 : initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

package stm_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } stm_state_e;

  localparam int SEQ_PERIOD = 3;
  // bit[phase] is the symbol the generator emits at that phase: 0,0,1
  localparam logic [SEQ_PERIOD-1:0] SEQ_PATTERN = 3'b100;
  localparam logic [1:0] LAST_PHASE = 2'(SEQ_PERIOD - 1);

  function automatic logic [1:0] next_phase(input logic [1:0] p);
    return (p == LAST_PHASE) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic expected_bit(input logic [1:0] p);
    return SEQ_PATTERN[p];
  endfunction

endpackage

`default_nettype wire

// File: rtl/stm_sat_cnt.sv
// +-----------------------------------------------------------------------------+
// | stm_sat_cnt : up-counter that sticks at all-ones, with synchronous clear    |
// | Rev 1.0 : initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

module stm_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != C_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q = cnt_q;

endmodule

`default_nettype wire

// File: rtl/stm_seq_checker.sv
// +-----------------------------------------------------------------------------+
// | stm_seq_checker : alignment, lock and bit-error monitor for the 0,0,1 stream |
// | Rev 1.0 : initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

module stm_seq_checker
  import stm_pkg::*;
#(
  parameter int ACQ_FRAMES = 2,
  parameter int LOSS_ERRS  = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             en,
  input  logic             Y_in,
  output logic             locked,
  output logic             frame_pulse,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int FRM_W  = $clog2(ACQ_FRAMES + 1);
  localparam int MISS_W = $clog2(LOSS_ERRS + 1);
  // Thresholds are compared against the count before this sample's increment
  localparam logic [FRM_W-1:0]  C_ACQ_LAST  = FRM_W'(ACQ_FRAMES - 1);
  localparam logic [MISS_W-1:0] C_LOSS_LAST = MISS_W'(LOSS_ERRS - 1);

  stm_state_e        state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic              locked_q, locked_d;
  logic              frame_pulse_q, frame_pulse_d;
  logic              err_pulse_q, err_pulse_d;

  logic [FRM_W-1:0]  frm_cnt;
  logic [MISS_W-1:0] miss_cnt;
  logic              frm_clr, frm_inc;
  logic              miss_clr, miss_inc;
  logic              err_inc;
  logic              bit_ok;

  assign bit_ok = (Y_in == expected_bit(phase_q));

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    frm_clr       = 1'b0;
    frm_inc       = 1'b0;
    miss_clr      = 1'b0;
    miss_inc      = 1'b0;
    err_inc       = 1'b0;
    frame_pulse_d = 1'b0;
    err_pulse_d   = 1'b0;

    if (en) begin
      case (state_q)
        HUNT: begin
          // A 1 closes a frame, so the next bit is phase 0
          if (Y_in) begin
            state_d = VERIFY;
            phase_d = 2'd0;
            frm_clr = 1'b1;
          end
        end

        VERIFY: begin
          phase_d = next_phase(phase_q);
          if (bit_ok) begin
            if (phase_q == LAST_PHASE) begin
              if (frm_cnt == C_ACQ_LAST) begin
                state_d  = LOCK;
                frm_clr  = 1'b1;
                miss_clr = 1'b1;
              end else begin
                frm_inc = 1'b1;
              end
            end
          end else if (Y_in) begin
            // Early 1: treat it as the true frame end and restart acquisition
            phase_d = 2'd0;
            frm_clr = 1'b1;
          end else begin
            state_d = HUNT;
            phase_d = 2'd0;
          end
        end

        LOCK: begin
          phase_d = next_phase(phase_q);
          if (bit_ok) begin
            miss_clr      = 1'b1;
            frame_pulse_d = (phase_q == LAST_PHASE);
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            if (miss_cnt == C_LOSS_LAST) begin
              state_d  = HUNT;
              phase_d  = 2'd0;
              miss_clr = 1'b1;
            end else begin
              miss_inc = 1'b1;
            end
          end
        end

        default: begin
          state_d = HUNT;
          phase_d = 2'd0;
        end
      endcase
    end

    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q       <= HUNT;
      phase_q       <= 2'd0;
      locked_q      <= 1'b0;
      frame_pulse_q <= 1'b0;
      err_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      locked_q      <= locked_d;
      frame_pulse_q <= frame_pulse_d;
      err_pulse_q   <= err_pulse_d;
    end
  end

  stm_sat_cnt #(.W(FRM_W)) u_frm_cnt (
    .clk (clk),
    .Rst (Rst),
    .clr (frm_clr),
    .inc (frm_inc),
    .q   (frm_cnt)
  );

  stm_sat_cnt #(.W(MISS_W)) u_miss_cnt (
    .clk (clk),
    .Rst (Rst),
    .clr (miss_clr),
    .inc (miss_inc),
    .q   (miss_cnt)
  );

  stm_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .Rst (Rst),
    .clr (1'b0),
    .inc (err_inc),
    .q   (err_count)
  );

  assign locked      = locked_q;
  assign frame_pulse = frame_pulse_q;
  assign err_pulse   = err_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_stm_seq_checker.sv
// +-----------------------------------------------------------------------------+
// | tb_stm_seq_checker : directed self-checking bench for stm_seq_checker       |
// | Rev 1.0 : initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_stm_seq_checker;

  logic       clk = 1'b0;
  logic       Rst;
  logic       en;
  logic       Y_in;

  logic       locked, frame_pulse, err_pulse;
  logic [7:0] err_count;
  logic       s_locked, s_frame_pulse, s_err_pulse;
  logic [1:0] s_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stm_seq_checker #(.ACQ_FRAMES(2), .LOSS_ERRS(3), .CNT_W(8)) dut (
    .clk         (clk),
    .Rst         (Rst),
    .en          (en),
    .Y_in        (Y_in),
    .locked      (locked),
    .frame_pulse (frame_pulse),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  // Same stimulus, small counter and lenient loss threshold for saturation
  stm_seq_checker #(.ACQ_FRAMES(2), .LOSS_ERRS(8), .CNT_W(2)) dut_sat (
    .clk         (clk),
    .Rst         (Rst),
    .en          (en),
    .Y_in        (Y_in),
    .locked      (s_locked),
    .frame_pulse (s_frame_pulse),
    .err_pulse   (s_err_pulse),
    .err_count   (s_err_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic send(input logic y);
    en   = 1'b1;
    Y_in = y;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en   = 1'b0;
    Y_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Rst  = 1'b1;
    en   = 1'b0;
    Y_in = 1'b0;
    @(posedge clk);
    #1;
    Rst  = 1'b0;
  endtask

  // 1,0,0,1,0,0,1 : HUNT->VERIFY then two good frames
  task automatic acquire(input string tag, input int gaps);
    logic [6:0] acq_seq;
    acq_seq = 7'b1001001;
    for (int i = 0; i < 7; i++) begin
      send(acq_seq[6-i]);
      check({tag, "_fp"}, frame_pulse, 1'b0);
      check({tag, "_lock"}, locked, (i == 6) ? 1'b1 : 1'b0);
      if (i != 6) begin
        for (int g = 0; g < gaps; g++) begin
          idle();
          check({tag, "_gap_lock"}, locked, 1'b0);
        end
      end
    end
  endtask

  initial begin
    Rst  = 1'b1;
    en   = 1'b0;
    Y_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", locked, 1'b0);
    check("rst_fp", frame_pulse, 1'b0);
    check("rst_ep", err_pulse, 1'b0);
    check("rst_cnt", err_count, 8'd0);
    Rst = 1'b0;

    acquire("acq", 0);
    check("acq_cnt", err_count, 8'd0);

    // Locked stream: frame_pulse after every third sample
    for (int i = 0; i < 9; i++) begin
      send((i % 3) == 2);
      check("strm_fp", frame_pulse, ((i % 3) == 2) ? 1'b1 : 1'b0);
      check("strm_ep", err_pulse, 1'b0);
      check("strm_lock", locked, 1'b1);
    end

    // Single error at phase 0, then the rest of the frame
    send(1'b1);
    check("err1_ep", err_pulse, 1'b1);
    check("err1_cnt", err_count, 8'd1);
    check("err1_lock", locked, 1'b1);
    idle();
    check("err1_gap_ep", err_pulse, 1'b0);
    send(1'b0);
    check("err1_ph1_ep", err_pulse, 1'b0);
    send(1'b1);
    check("err1_fp", frame_pulse, 1'b1);
    check("err1_lock2", locked, 1'b1);

    // Loss of lock: 1,1,0 at phases 0,1,2
    do_reset();
    acquire("acq2", 0);
    begin
      logic [2:0] bad;
      bad = 3'b110;
      for (int i = 0; i < 3; i++) begin
        send(bad[2-i]);
        check("loss_ep", err_pulse, 1'b1);
        check("loss_cnt", err_count, 32'(i + 1));
        check("loss_lock", locked, (i == 2) ? 1'b0 : 1'b1);
      end
    end
    send(1'b0);
    check("hunt_lock", locked, 1'b0);
    check("hunt_ep", err_pulse, 1'b0);
    check("hunt_cnt", err_count, 8'd3);

    // en gaps between every sample
    do_reset();
    acquire("gap", 2);

    // Realign in VERIFY: stray 1 at phase 1
    do_reset();
    send(1'b1);
    send(1'b0);
    send(1'b1);
    check("realign_lock", locked, 1'b0);
    send(1'b0); send(1'b0); send(1'b1);
    check("realign_f1_lock", locked, 1'b0);
    send(1'b0); send(1'b0); send(1'b1);
    check("realign_f2_lock", locked, 1'b1);
    check("realign_fp", frame_pulse, 1'b0);

    // Saturation on the CNT_W=2 instance: five consecutive bad bits
    do_reset();
    acquire("acq3", 0);
    check("sat_acq_lock", s_locked, 1'b1);
    begin
      logic [4:0] bad5;
      bad5 = 5'b11011;
      for (int i = 0; i < 5; i++) begin
        send(bad5[4-i]);
        check("sat_ep", s_err_pulse, 1'b1);
        check("sat_cnt", s_err_count, (i >= 2) ? 2'd3 : 2'(i + 1));
        check("sat_lock", s_locked, 1'b1);
      end
    end

    // Reset mid-frame while a pulse is active and en is high
    Rst  = 1'b1;
    en   = 1'b1;
    Y_in = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_s_lock", s_locked, 1'b0);
    check("mrst_s_ep", s_err_pulse, 1'b0);
    check("mrst_s_fp", s_frame_pulse, 1'b0);
    check("mrst_s_cnt", s_err_count, 2'd0);
    check("mrst_lock", locked, 1'b0);
    check("mrst_cnt", err_count, 8'd0);
    Rst = 1'b0;
    acquire("reacq", 0);
    check("reacq_s_lock", s_locked, 1'b1);
    check("reacq_s_cnt", s_err_count, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
